// File: rtl/msp430_pwm16.sv
// msp430_pwm16: 16-bit double-buffered PWM generator driven by the register-template control words.
// Optional sticky period-end interrupt flag is built when MSP430_PWM16_IRQ_EN is defined.
module msp430_pwm16 #(
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [15:0] period_in,
    input  logic [15:0] duty_in,
    input  logic        pwm_en,
    input  logic        irq_clr,
    output logic        pwm_out,
    output logic [15:0] cnt_val,
    output logic        period_end,
    output logic        pwm_irq
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [15:0] sh_period, sh_period_nxt;
    logic [15:0] sh_duty, sh_duty_nxt;
    logic        pwm_nxt;

    assign cnt_val    = cnt;
    assign period_end = (state == RUN) && (cnt == sh_period);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        sh_period_nxt = sh_period;
        sh_duty_nxt   = sh_duty;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (pwm_en && (period_in != '0))
                    state_nxt = LOAD;
            end
            LOAD: begin
                cnt_nxt       = '0;
                sh_period_nxt = period_in;
                sh_duty_nxt   = duty_in;
                state_nxt     = RUN;
            end
            RUN: begin
                if (cnt == sh_period) begin
                    cnt_nxt = '0;
                    if (!pwm_en || (period_in == '0)) begin
                        state_nxt = IDLE;
                    end else begin
                        sh_period_nxt = period_in;
                        sh_duty_nxt   = duty_in;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Output is derived from next-state values so the register lines up with cnt_val.
        pwm_nxt = ((state_nxt == RUN) && (cnt_nxt < sh_duty_nxt)) ? ~IDLE_LVL : IDLE_LVL;
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sh_period <= '0;
            sh_duty   <= '0;
            pwm_out   <= IDLE_LVL;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sh_period <= sh_period_nxt;
            sh_duty   <= sh_duty_nxt;
            pwm_out   <= pwm_nxt;
        end
    end

`ifdef MSP430_PWM16_IRQ_EN
    logic irq;

    // A new period end takes priority over a coincident clear.
    always_ff @(posedge mclk) begin
        if (puc_rst)
            irq <= 1'b0;
        else if (period_end)
            irq <= 1'b1;
        else if (irq_clr)
            irq <= 1'b0;
    end

    assign pwm_irq = irq;
`else
    logic irq_clr_unused;
    assign irq_clr_unused = irq_clr;
    assign pwm_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_msp430_pwm16.sv
// tb_msp430_pwm16: directed self-checking bench for msp430_pwm16 (IDLE_LVL = 0).
// Exercises the IRQ flag when MSP430_PWM16_IRQ_EN is defined, otherwise checks it stays low.
module tb_msp430_pwm16;

    logic        mclk;
    logic        puc_rst;
    logic [15:0] period_in;
    logic [15:0] duty_in;
    logic        pwm_en;
    logic        irq_clr;
    logic        pwm_out;
    logic [15:0] cnt_val;
    logic        period_end;
    logic        pwm_irq;

    int unsigned n_checks;
    int unsigned n_fails;
    int unsigned act_cnt;

    msp430_pwm16 #(.IDLE_LVL(1'b0)) dut (
        .mclk      (mclk),
        .puc_rst   (puc_rst),
        .period_in (period_in),
        .duty_in   (duty_in),
        .pwm_en    (pwm_en),
        .irq_clr   (irq_clr),
        .pwm_out   (pwm_out),
        .cnt_val   (cnt_val),
        .period_end(period_end),
        .pwm_irq   (pwm_irq)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        puc_rst   = 1'b1;
        period_in = '0;
        duty_in   = '0;
        pwm_en    = 1'b0;
        irq_clr   = 1'b0;

        // Reset state
        tick();
        tick();
        check_value("rst_pwm", pwm_out, 0);
        check_value("rst_cnt", cnt_val, 0);
        check_value("rst_pe", period_end, 0);
        check_value("rst_irq", pwm_irq, 0);
        puc_rst = 1'b0;
        tick();
        check_value("idle_cnt", cnt_val, 0);

        // Basic waveform: period 4, duty 2
        period_in = 16'd4;
        duty_in   = 16'd2;
        pwm_en    = 1'b1;
        tick();
        check_value("load_cnt", cnt_val, 0);
        check_value("load_pwm", pwm_out, 0);
        check_value("load_pe", period_end, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_value("basic_cnt", cnt_val, i % 5);
            check_value("basic_pwm", pwm_out, ((i % 5) < 2) ? 1 : 0);
            check_value("basic_pe", period_end, ((i % 5) == 4) ? 1 : 0);
        end

        // Graceful stop: drop enable at cnt 2
        tick();
        tick();
        tick();
        check_value("stop_cnt2", cnt_val, 2);
        pwm_en = 1'b0;
        tick();
        check_value("stop_cnt3", cnt_val, 3);
        tick();
        check_value("stop_cnt4", cnt_val, 4);
        check_value("stop_pe", period_end, 1);
        tick();
        check_value("stop_idle_cnt", cnt_val, 0);
        check_value("stop_idle_pwm", pwm_out, 0);
        check_value("stop_idle_pe", period_end, 0);
        tick();
        check_value("stop_idle_cnt2", cnt_val, 0);

        // Zero period: enable must not start
        period_in = 16'd0;
        pwm_en    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_value("zp_cnt", cnt_val, 0);
            check_value("zp_pwm", pwm_out, 0);
            check_value("zp_pe", period_end, 0);
        end

        // Double buffering: period 9, duty 3, rewrite duty to 7 at cnt 5
        period_in = 16'd9;
        duty_in   = 16'd3;
        tick();
        check_value("db_load_pwm", pwm_out, 0);
        act_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_value("db_cnt", cnt_val, i % 10);
            check_value("db_pwm", pwm_out, ((i % 10) < ((i < 10) ? 3 : 7)) ? 1 : 0);
            act_cnt += pwm_out;
            if (i == 5) duty_in = 16'd7;
            if (i == 9) begin
                check_value("db_width_a", act_cnt, 3);
                act_cnt = 0;
            end
            if (i == 19) check_value("db_width_b", act_cnt, 7);
        end

        // Duty extremes, period 4 (last cycle above was the boundary)
        period_in = 16'd4;
        duty_in   = 16'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_value("d0_cnt", cnt_val, i % 5);
            check_value("d0_pwm", pwm_out, 0);
            check_value("d0_pe", period_end, ((i % 5) == 4) ? 1 : 0);
        end
        duty_in = 16'd10;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_value("d10_cnt", cnt_val, i % 5);
            check_value("d10_pwm", pwm_out, 1);
            check_value("d10_pe", period_end, ((i % 5) == 4) ? 1 : 0);
        end

        // Reset mid-period at cnt 3
        tick();
        tick();
        tick();
        tick();
        check_value("mr_cnt3", cnt_val, 3);
        puc_rst = 1'b1;
        tick();
        puc_rst = 1'b0;
        check_value("mr_cnt", cnt_val, 0);
        check_value("mr_pwm", pwm_out, 0);
        check_value("mr_pe", period_end, 0);
        check_value("mr_irq", pwm_irq, 0);
        tick();
        check_value("mr_load_cnt", cnt_val, 0);
        check_value("mr_load_pwm", pwm_out, 0);
        tick();
        check_value("mr_run_cnt", cnt_val, 0);
        check_value("mr_run_pwm", pwm_out, 1);
        tick();
        check_value("mr_run_cnt1", cnt_val, 1);
        tick();
        tick();
        tick();
        check_value("mr_cnt4", cnt_val, 4);
        check_value("mr_pe4", period_end, 1);

`ifdef MSP430_PWM16_IRQ_EN
        check_value("irq_pre", pwm_irq, 0);
        tick();
        check_value("irq_set_cnt", cnt_val, 0);
        check_value("irq_set", pwm_irq, 1);
        tick();
        check_value("irq_hold", pwm_irq, 1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check_value("irq_cleared", pwm_irq, 0);
        tick();
        tick();
        check_value("irq_pe_cnt", cnt_val, 4);
        check_value("irq_pe", period_end, 1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check_value("irq_set_wins", pwm_irq, 1);
`else
        for (int i = 0; i < 10; i++) begin
            irq_clr = (i % 3) == 0;
            tick();
            check_value("irq_off", pwm_irq, 0);
        end
        irq_clr = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
